fetch_stage: RTL and testbench

Instruction fetch stage of the pipelined RV32I core. Holds the program counter and issues word reads to a synchronous instruction memory with fixed one-cycle read latency. Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake. Decode feeds the instruction to the immediate generator. Supports redirect (taken branch/jump) with flush of buffered and in-flight wrong-path instructions.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush; head is
// visible combinationally so decode sees the oldest word without extra latency.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  fetch_entry_t               data_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output fetch_entry_t               head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_entry_t        mem_q [DEPTH];
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == DEPTH_C);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a push into a full FIFO is fine then.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one-deep in-flight tracking against a 1-cycle imem,
// wrong-path kill on redirect, and a buffered valid/ready output to decode.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic          inflight_q, inflight_d;
   logic          kill_q, kill_d;

   logic          pop, push, req;
   logic [CW:0]   occ;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  fifo_head, push_entry;

   assign pop = valid_o && ready_i;

   // Slots that will be taken after this cycle, counting the response in flight.
   assign occ = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
   assign req = rst_n && !redirect_i && (occ < DEPTH_C);

   assign push             = inflight_q && !kill_q && !redirect_i && (!fifo_full || pop);
   assign push_entry.pc    = inflight_pc_q;
   assign push_entry.instr = imem_rdata_i;

   assign imem_req_o  = req;
   assign imem_addr_o = pc_q;

   always_comb begin
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = req;
      kill_d        = 1'b0;
      if (redirect_i) begin
         pc_d   = redirect_pc_i & 32'hFFFF_FFFC;
         kill_d = inflight_q;
      end else if (req) begin
         pc_d          = pc_q + 32'd4;
         inflight_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         inflight_pc_q <= '0;
         inflight_q    <= 1'b0;
         kill_q        <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
         kill_q        <= kill_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop && !redirect_i),
      .flush_i (redirect_i),
      .data_i  (push_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

   assign valid_o = !fifo_empty;
   assign instr_o = valid_o ? fifo_head.instr : NOP_INSTR;
   assign pc_o    = valid_o ? fifo_head.pc    : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall, redirects, wrap and async reset.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        valid;
   logic        ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_rdata = 32'h0;
   logic        w_valid;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic        w_ready = 1'b1;
   logic        w_redirect = 1'b0;
   logic [31:0] w_redirect_pc = 32'h0;

   logic        saw_40 = 1'b0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
      .valid_o(valid), .ready_i(ready), .instr_o(instr), .pc_o(pc),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_rdata_i(w_rdata),
      .valid_o(w_valid), .ready_i(w_ready), .instr_o(w_instr), .pc_o(w_pc),
      .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc)
   );

   // Instruction memory model: one-cycle read latency, data = addr ^ A5A5_0000.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= imem_addr ^ 32'hA5A5_0000;
      if (rst_n && imem_req && imem_addr == 32'h0000_0040) saw_40 <= 1'b1;
   end

   always @(posedge clk) begin
      if (rst_n && valid && ready)
         $display("xfer pc=%h instr=%h redirect=%0b", pc, instr, redirect);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic deliv(input string tag, input logic [31:0] epc);
      chk({tag, "_valid"}, {31'b0, valid}, 32'd1);
      chk({tag, "_pc"}, pc, epc);
      chk({tag, "_instr"}, instr, epc ^ 32'hA5A5_0000);
   endtask

   task automatic reqchk(input string tag, input logic [31:0] eaddr);
      chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
      chk({tag, "_addr"}, imem_addr, eaddr);
   endtask

   initial begin
      rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
      repeat (3) cyc();
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_pc", pc, 32'h0);
      chk("rst_wrap_req", {31'b0, w_req}, 32'd0);

      // Streaming with ready held high.
      rst_n = 1'b1; #1;
      reqchk("s0", 32'h0);
      chk("s0_valid", {31'b0, valid}, 32'd0);
      chk("wrap0", w_addr, 32'hFFFF_FFF8);
      cyc();
      reqchk("s1", 32'h4);
      chk("s1_valid", {31'b0, valid}, 32'd0);
      chk("wrap1", w_addr, 32'hFFFF_FFFC);
      cyc();
      chk("wrap2", w_addr, 32'h0000_0000);
      chk("wrap2_req", {31'b0, w_req}, 32'd1);
      for (int k = 2; k <= 9; k++) begin
         if (k > 2) cyc();
         deliv($sformatf("s%0d", k), 32'(4 * (k - 2)));
         reqchk($sformatf("s%0d", k), 32'(4 * k));
      end

      // Asynchronous reset mid-stream, then stall from a fresh start.
      cyc();
      rst_n = 1'b0; #1;
      chk("arst_valid", {31'b0, valid}, 32'd0);
      chk("arst_req", {31'b0, imem_req}, 32'd0);
      chk("arst_instr", instr, 32'h0000_0013);
      ready = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1; #1;
      reqchk("st0", 32'h0);
      chk("st0_wrap", w_addr, 32'hFFFF_FFF8);
      cyc();
      reqchk("st1", 32'h4);
      chk("st1_valid", {31'b0, valid}, 32'd0);
      cyc();
      deliv("st2", 32'h0);
      chk("st2_req", {31'b0, imem_req}, 32'd0);
      for (int k = 3; k <= 5; k++) begin
         cyc();
         deliv($sformatf("st%0d", k), 32'h0);
         chk($sformatf("st%0d_req", k), {31'b0, imem_req}, 32'd0);
      end
      cyc(); ready = 1'b1; #1;
      deliv("st6", 32'h0);  reqchk("st6", 32'h8);
      cyc(); deliv("st7", 32'h4);  reqchk("st7", 32'hC);
      cyc(); deliv("st8", 32'h8);  reqchk("st8", 32'h10);
      cyc(); deliv("st9", 32'hC);  reqchk("st9", 32'h14);

      // Redirect to 0x100 while the in-flight word arrives and decode stalls.
      cyc(); ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100; #1;
      deliv("r0", 32'h10);
      chk("r0_req", {31'b0, imem_req}, 32'd0);
      cyc(); redirect = 1'b0; #1;
      chk("r1_valid", {31'b0, valid}, 32'd0);
      reqchk("r1", 32'h100);
      cyc();
      chk("r2_valid", {31'b0, valid}, 32'd0);
      reqchk("r2", 32'h104);
      cyc();
      deliv("r3", 32'h100);
      chk("r3_req", {31'b0, imem_req}, 32'd0);
      cyc();

      // Redirect to an unaligned target with a coinciding handshake.
      ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0203; #1;
      deliv("r4", 32'h100);
      chk("r4_req", {31'b0, imem_req}, 32'd0);
      cyc(); redirect = 1'b0; #1;
      chk("q1_valid", {31'b0, valid}, 32'd0);
      reqchk("q1", 32'h200);
      cyc();
      chk("q2_valid", {31'b0, valid}, 32'd0);
      reqchk("q2", 32'h204);
      cyc();
      deliv("q3", 32'h200);

      // Back-to-back redirects: 0x40 then 0x80.
      redirect = 1'b1; redirect_pc = 32'h0000_0040; #1;
      chk("q3_req", {31'b0, imem_req}, 32'd0);
      cyc(); redirect_pc = 32'h0000_0080; #1;
      chk("q4_valid", {31'b0, valid}, 32'd0);
      chk("q4_req", {31'b0, imem_req}, 32'd0);
      cyc(); redirect = 1'b0; #1;
      chk("q5_valid", {31'b0, valid}, 32'd0);
      reqchk("q5", 32'h80);
      cyc();
      chk("q6_valid", {31'b0, valid}, 32'd0);
      reqchk("q6", 32'h84);
      cyc();
      deliv("q7", 32'h80);
      reqchk("q7", 32'h88);
      cyc();
      deliv("q8", 32'h84);
      chk("no_0x40_fetch", {31'b0, saw_40}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
